// File: rtl/mcu_core_pkg.sv
// mcu_core_pkg -- shared definitions for the mcu_core slice.
// Contents: FSM state encoding, opcode encoding, instruction field widths
// and helpers that locate the rd/rs fields for a given WIDTH and RW.
package mcu_core_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_MEM   = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_NOT  = 4'h6,
      OP_LDI  = 4'h7,
      OP_LD   = 4'h8,
      OP_ST   = 4'h9,
      OP_IN   = 4'hA,
      OP_OUT  = 4'hB,
      OP_JMP  = 4'hC,
      OP_JZ   = 4'hD,
      OP_RSVD = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned IMM_W = 8;

   // MSB of the rd field: directly below the opcode.
   function automatic int unsigned rd_msb(input int unsigned width);
      return width - OP_W - 1;
   endfunction

   // MSB of the rs field: directly below rd.
   function automatic int unsigned rs_msb(input int unsigned width, input int unsigned rw);
      return width - OP_W - rw - 1;
   endfunction

   // Opcodes 1..6 are the ones computed by the ALU and the only ones touching Z.
   function automatic logic is_alu_op(input opcode_e op);
      return (op >= OP_ADD) && (op <= OP_NOT);
   endfunction

endpackage

// File: rtl/mcu_core_alu.sv
// mcu_alu -- combinational ALU for opcodes ADD..NOT.
// Ports:
//   op_i     : opcode (only ADD/SUB/AND/OR/XOR/NOT produce a result)
//   a_i      : first operand (rd value)
//   b_i      : second operand (rs value)
//   result_o : result, modulo 2^WIDTH
//   zero_o   : 1 when result_o is zero
module mcu_alu
   import mcu_core_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  opcode_e          op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);

   // Operation select; carries/borrows fall off the top bit.
   always_comb begin
      result_o = '0;
      case (op_i)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_NOT:  result_o = ~b_i;
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/mcu_core.sv
// mcu_core -- minimal multi-cycle accumulator-less MCU core.
// Executes FETCH -> EXEC [-> MEM] per instruction against a handshake memory.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem_req/mem_we      : memory request, write enable
//   mem_addr/mem_wdata  : request address / write data (held until ack)
//   mem_rdata/mem_ack   : read data, completion pulse (ignored while idle)
//   port_in/port_out    : I/O input, registered I/O output
//   halted              : core stopped by HALT until reset
module mcu_core
   import mcu_core_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREG  = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] port_in,
   output logic [WIDTH-1:0] port_out,
   output logic             halted
);

   localparam int          RW     = $clog2(NREG);
   localparam int unsigned RD_MSB = rd_msb(WIDTH);
   localparam int unsigned RS_MSB = rs_msb(WIDTH, RW);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic             z_q, z_d;
   logic [WIDTH-1:0] port_out_q, port_out_d;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];

   opcode_e          op_s;
   logic [RW-1:0]    rd_s;
   logic [RW-1:0]    rs_s;
   logic [WIDTH-1:0] imm_s;
   logic [WIDTH-1:0] rd_val_s;
   logic [WIDTH-1:0] rs_val_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_zero_s;
   logic             mem_req_s;
   logic             mem_we_s;
   logic [WIDTH-1:0] mem_addr_s;
   logic [WIDTH-1:0] mem_wdata_s;

   assign op_s     = opcode_e'(ir_q[WIDTH-1 -: OP_W]);
   assign rd_s     = ir_q[RD_MSB -: RW];
   assign rs_s     = ir_q[RS_MSB -: RW];
   assign imm_s    = {{(WIDTH-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
   // Both operands come from the registered file, so rd==rs sees the old value twice.
   assign rd_val_s = regs_q[rd_s];
   assign rs_val_s = regs_q[rs_s];

   mcu_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op_i     (op_s),
      .a_i      (rd_val_s),
      .b_i      (rs_val_s),
      .result_o (alu_res_s),
      .zero_o   (alu_zero_s)
   );

   // Next-state, commit and memory-interface decode.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      z_d         = z_q;
      port_out_d  = port_out_q;
      regs_d      = regs_q;
      mem_req_s   = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = pc_q;
      mem_wdata_s = '0;

      case (state_q)
         ST_FETCH: begin
            mem_req_s  = 1'b1;
            mem_addr_s = pc_q;
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + WIDTH'(1);
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FETCH;
            end
         end

         ST_EXEC: begin
            state_d = ST_FETCH;
            case (op_s)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                  regs_d[rd_s] = alu_res_s;
                  z_d          = alu_zero_s;
               end
               OP_LDI:  regs_d[rd_s] = imm_s;
               OP_LD:   state_d = ST_MEM;
               OP_ST:   state_d = ST_MEM;
               OP_IN:   regs_d[rd_s] = port_in;
               OP_OUT:  port_out_d = rd_val_s;
               OP_JMP:  pc_d = imm_s;
               OP_JZ: begin
                  if (z_q) begin
                     pc_d = imm_s;
                  end else begin
                     pc_d = pc_q;
                  end
               end
               OP_HALT: state_d = ST_HALT;
               default: state_d = ST_FETCH;
            endcase
         end

         ST_MEM: begin
            mem_req_s   = 1'b1;
            mem_addr_s  = rs_val_s;
            mem_we_s    = (op_s == OP_ST);
            mem_wdata_s = rd_val_s;
            if (mem_ack) begin
               if (op_s == OP_LD) begin
                  regs_d[rd_s] = mem_rdata;
               end else begin
                  regs_d[rd_s] = regs_q[rd_s];
               end
               state_d = ST_FETCH;
            end else begin
               state_d = ST_MEM;
            end
         end

         ST_HALT: state_d = ST_HALT;

         default: state_d = ST_FETCH;
      endcase
   end

   // State and architectural registers; reset returns to a fetch at address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         pc_q       <= '0;
         ir_q       <= '0;
         z_q        <= 1'b0;
         port_out_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         z_q        <= z_d;
         port_out_q <= port_out_d;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Request is gated by rst so a transaction in flight is dropped in the reset cycle.
   assign mem_req   = mem_req_s & ~rst;
   assign mem_we    = mem_we_s;
   assign mem_addr  = mem_addr_s;
   assign mem_wdata = mem_wdata_s;
   assign port_out  = port_out_q;
   assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/mcu_core.md
MCU_CORE -- requirements
Module: mcu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data/address/instruction width; legal iff WIDTH >= 12 + 2*RW.
REQ-002 SHALL have parameter NREG, default 4, meaning general-purpose register count (power of 2, >= 2); RW = log2(NREG).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_req  output  1  memory transaction request.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-007 SHALL have port mem_addr  output  WIDTH  transaction address; valid while mem_req.
REQ-008 SHALL have port mem_wdata  output  WIDTH  write data; valid while mem_req and mem_we.
REQ-009 SHALL have port mem_rdata  input  WIDTH  read data; sampled on the edge where mem_ack is 1.
REQ-010 SHALL have port mem_ack  input  1  memory function complete; single-cycle pulse.
REQ-011 SHALL have port port_in  input  WIDTH  I/O input port.
REQ-012 SHALL have port port_out  output  WIDTH  registered I/O output port.
REQ-013 SHALL have port halted  output  1  core stopped by HALT.

Function
REQ-014 Instruction fields SHALL be: op = instr[WIDTH-1:WIDTH-4], rd = next RW bits down, rs = next RW bits down, imm = instr[7:0] zero-extended to WIDTH.
REQ-015 Opcodes SHALL be: 0 NOP; 1 ADD rd=rd+rs; 2 SUB rd=rd-rs; 3 AND; 4 OR; 5 XOR; 6 NOT rd=~rs; 7 LDI rd=imm; 8 LD rd=mem[rs]; 9 ST mem[rs]=rd; A IN rd=port_in; B OUT port_out=rd; C JMP pc=imm; D JZ pc=imm if Z; E reserved, executes as NOP; F HALT.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; carry/borrow discarded.
REQ-017 Flag Z SHALL update only on opcodes 1-6, set iff the result is 0; all other opcodes leave Z unchanged.
REQ-018 FSM states SHALL be FETCH, EXEC, MEM, HALT.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, IR<=mem_rdata, pc<=pc+1 (wraps 2^WIDTH-1 -> 0), go EXEC.
REQ-020 EXEC: one cycle, mem_req=0; LD/ST go MEM; HALT goes HALT; all others commit result and go FETCH.
REQ-021 MEM: mem_req=1, mem_addr=reg[rs], mem_we=1 for ST (mem_wdata=reg[rd]); on mem_ack, LD writes rd, go FETCH.
REQ-022 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the edge sampling mem_ack=1, and mem_req SHALL be 0 in the following cycle.
REQ-023 mem_ack while mem_req=0 SHALL be ignored.
REQ-024 Non-memory instruction latency SHALL be (fetch wait + 1) + 1 cycles; with zero-wait memory (ack in first request cycle), 2 cycles per instruction, 3 for LD/ST.
REQ-025 JMP/JZ-taken SHALL overwrite the incremented pc; the next FETCH uses the new pc.
REQ-026 HALT state SHALL be absorbing: halted=1, mem_req=0, no register/port changes until rst.
REQ-027 Register written by ALU op with rd==rs SHALL use the old value as both operands.

Reset
REQ-028 While rst=1 on an edge: pc=0, all registers=0, Z=0, IR=0, port_out=0, state=FETCH.
REQ-029 mem_req SHALL be 0 in any cycle where rst=1; halted SHALL be 0 after reset.
REQ-030 Reset mid-transaction SHALL abort it; a late mem_ack after reset is covered by REQ-023 only if mem_req=0, otherwise it completes the new fetch at pc=0.
REQ-031 First fetch (address 0) SHALL be requested in the first cycle after rst deasserts.

Structure
REQ-032 Opcode constants, state encodings and field-position helpers SHALL live in shared definitions file mcu_defs.vh.
REQ-033 Opcodes 1-6 SHALL be computed by one sub-module mcu_alu (WIDTH-parametrised, combinational, outputs result and zero).
REQ-034 The register file SHALL be an NREG x WIDTH array inside mcu_core, no tri-state buses internally.

Verification
REQ-035 Zero-wait memory, program LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT -> port_out=8 at cycle 8 after reset release, halted=1 at cycle 10.
REQ-036 SUB r0,r0 then JZ 0x20 -> Z=1, next mem_addr=0x0020; same with r0=1 before SUB r0,r1 (r1=0) -> JZ falls through.
REQ-037 Memory responder with 3-cycle ack delay on LD r2,[r1], r1=0x40, mem[0x40]=0xBEEF -> mem_req held 4 cycles with addr 0x0040 stable, r2=0xBEEF.
REQ-038 ST r3,[r0] with r3=0x1234, r0=0x10 -> one request, mem_we=1, addr 0x0010, wdata 0x1234; spurious ack while idle causes no state change.
REQ-039 Assert rst during a waiting LD -> mem_req=0 that cycle, all registers/port_out 0, next request addr 0x0000.
REQ-040 WIDTH=24, NREG=8: ADD on 0xFFFFFF+1 -> 0, Z=1; pc at 0xFFFFFF wraps to 0.
